// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main control FSM of the multicycle RV32I core.
// Ports: clk/reset (sync, active-high); op = instr[6:0]; Zero = ALU zero flag;
// PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite enables; ResultSrc, ALUSrcA,
// ALUSrcB, ALUOp, ImmSrc mux selects; halted = in HALT;
// instret = retired-instruction count, present only with MULTICYCLE_INSTRET_EN.
module multicycle_ctrl_fsm #(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       halted
`ifdef MULTICYCLE_INSTRET_EN
  ,
  output logic [CNT_W-1:0] instret
`endif
);
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_B  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_HALT
  } state_t;

  state_t state_q, state_d;
  logic   pc_update, branch;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:   state_d = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                            (op == OP_R) ? S_EXECR :
                            (op == OP_I) ? S_EXECI :
                            (op == OP_J) ? S_JAL :
                            (op == OP_B) ? S_BEQ :
                            (ILLEGAL_HALT ? S_HALT : S_FETCH);
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Outputs decode the current state directly; reset masks everything so no
  // write strobe can leak out while the FSM is being pulled back to FETCH.
  always_comb begin
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    RegWrite  = 1'b0;
    halted    = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          IRWrite   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          pc_update = 1'b1;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_MEMREAD: AdrSrc = 1'b1;
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b10;
        end
        S_EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b10;
        end
        S_ALUWB: RegWrite = 1'b1;
        S_JAL: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          pc_update = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b01;
          branch  = 1'b1;
        end
        S_HALT: halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
    PCWrite = pc_update | (branch & Zero);
  end

  assign ImmSrc = reset       ? 2'b00 :
                  (op == OP_SW) ? 2'b01 :
                  (op == OP_B)  ? 2'b10 :
                  (op == OP_J)  ? 2'b11 : 2'b00;

`ifdef MULTICYCLE_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;
  // Only the final state of a completed instruction retires it; the
  // illegal-opcode skip leaves from DECODE and is deliberately not counted.
  assign instret_d = (state_q == S_MEMWB || state_q == S_MEMWRITE ||
                      state_q == S_ALUWB || state_q == S_BEQ) ?
                     instret_q + CNT_W'(1) : instret_q;
  assign instret   = instret_q;
`endif

  always_ff @(posedge clk) begin
    state_q <= reset ? S_FETCH : state_d;
`ifdef MULTICYCLE_INSTRET_EN
    instret_q <= reset ? '0 : instret_d;
`endif
  end
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multicycle RV32I core variant. It sequences the shared ALU, instruction/data memory port, PC and register file over several cycles per instruction.
- Decodes opcode bits [6:0] into per-state enables and mux selects.
- Drives the 2-bit ALUOp consumed by the existing ALU decoder, which still produces the 4-bit ALUControl from funct3/funct7b5.
- Instantiated next to the ALU decoder inside the controller, between the instruction register and the datapath.

Parameters:
- CNT_W, 32: width of the optional retired-instruction counter.
- ILLEGAL_HALT, 1: 1 = an unrecognised opcode in Decode enters HALT; 0 = returns to FETCH, so the instruction is skipped.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  7  instr[6:0] from the instruction register.
- Zero  in  1  ALU zero flag.
- PCWrite  out  1  PC load enable; equals PCUpdate | (Branch & Zero).
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register / OldPC load enable.
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 data.
- ALUSrcB  out  2  ALU B select: 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- RegWrite  out  1  register file write enable.
- halted  out  1  high while in HALT.
- instret  out  CNT_W  retired count; present only with the optional feature.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ, HALT. The state register is the only storage besides the optional counter.
- Outputs are a combinational function of the current state (plus Zero and op).
- Any output not listed for a state is 0.
- reset high at an edge forces state to FETCH, mid-instruction included. No partial write is completed.
- While reset is high, all outputs are forced to 0 (PCWrite, IRWrite, MemWrite, RegWrite, and all selects); halted = 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other opcode -> HALT if ILLEGAL_HALT, else FETCH
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Next state FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next state FETCH. PCWrite is high only if Zero=1 in that cycle.
- HALT: all outputs 0, halted=1. HALT is absorbing; only reset leaves it.
- ImmSrc is decoded from op in every state:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - everything else -> 00
- Cycles per instruction, FETCH to next FETCH: lw 5, sw 4, R-type 4, I-type ALU 4, jal 4, beq 3.
- Zero is sampled only in BEQ and is ignored elsewhere.
- op must be stable from DECODE onward. IR is loaded only in FETCH.

Optional Feature:
- Macro: MULTICYCLE_INSTRET_EN.
- When defined:
  - Adds port instret (CNT_W bits), reset to 0.
  - Increments by 1 on each edge where the state leaves MEMWB, MEMWRITE, ALUWB or BEQ to FETCH with reset low.
  - Wraps from all-ones to 0.
  - Illegal-opcode skips (DECODE -> FETCH) do not count.
- When undefined: no instret port and no counter logic.

Test Plan:
- Reset held 2 cycles, then released with op=0110011 -> cycle 0 in FETCH (IRWrite=1, PCWrite=1), cycle 1 DECODE, cycle 2 EXECR (ALUOp=10, ALUSrcA=10, ALUSrcB=00), cycle 3 ALUWB (RegWrite=1), cycle 4 FETCH.
- op=0000011 -> sequence FETCH, DECODE, MEMADR, MEMREAD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1), FETCH; exactly 5 cycles; MemWrite=0 throughout.
- op=1100011: with Zero=1 in BEQ -> PCWrite=1, ALUOp=01; repeat with Zero=0 -> PCWrite=0; both return to FETCH after 3 cycles; ImmSrc=10 in all cycles.
- op=1101111 -> JAL with PCUpdate=1, ImmSrc=11, then ALUWB with RegWrite=1; op=0100011 -> MEMWRITE with MemWrite=1, ImmSrc=01.
- op=1111111 with ILLEGAL_HALT=1 -> HALT, halted=1, all enables 0 for 20 cycles; reset pulse -> FETCH. With ILLEGAL_HALT=0 -> FETCH directly after DECODE.
- MULTICYCLE_INSTRET_EN with CNT_W=4: run 17 R-type instructions -> instret reads 1 (wrap); reset asserted during MEMREAD -> next cycle FETCH, instret=0, RegWrite never asserted.
